spi_display_driver: RTL and testbench
=====================================

SPI_DISPLAY_DRIVER -- requirements
Module: spi_display_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 6, number of digit words per frame, legal range 1..8.
REQ-002 SHALL have parameter SCK_DIV, default 2, clk cycles per SCK half-period, legal range >=1.
REQ-003 SHALL have parameter INTENSITY, default 8, brightness code sent at init, legal range 0..15.
REQ-004 SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-005 SHALL have port res, input, 1, reset; synchronous and active-high.
REQ-006 SHALL have port start, input, 1, frame request, sampled each cycle.
REQ-007 SHALL have port digits, input, 4*NUM_DIGITS, BCD values; digit i occupies bits [4i+3:4i].
REQ-008 SHALL have port dp_mask, input, NUM_DIGITS, decimal point per digit; bit i belongs to digit i.
REQ-009 SHALL have port busy, output, 1, high while init or a frame is in progress.
REQ-010 SHALL have port done, output, 1, one-cycle pulse at the end of each frame.
REQ-011 SHALL have ports sck, mosi and cs_n, each output, 1, the SPI bus to a display controller (MAX7219-style).

Function
REQ-012 SHALL use the states INIT, IDLE, LOAD, SHIFT and GAP; INIT sends the 4 setup words, then goes to IDLE.
REQ-013 Init words, in order: 0x0C01 (shutdown off); 0x09 with decode mask (2^NUM_DIGITS)-1; 0x0B with scan limit NUM_DIGITS-1; 0x0A with INTENSITY.
REQ-014 Digit word i SHALL be {4'h0, 4'(i+1), dp_mask[i], 3'b000, digits[4i+3:4i]}.
REQ-015 Digit values 10..15 SHALL be passed through unchanged.
REQ-016 start SHALL be accepted only in IDLE; on acceptance, digits and dp_mask SHALL be latched in the same cycle.
REQ-017 Input changes after acceptance SHALL NOT affect the frame in flight.
REQ-018 start while busy=1 SHALL be ignored; requests SHALL NOT be queued.
REQ-019 A frame SHALL send digit words in order 0..NUM_DIGITS-1.
REQ-020 Word timing: cs_n low and MSB on mosi in the cycle after load; 16 bits MSB first.
REQ-021 Each bit SHALL drive sck low for SCK_DIV cycles, then high for SCK_DIV cycles.
REQ-022 mosi SHALL change only while sck is low (SPI mode 0).
REQ-023 After bit 0, sck and mosi SHALL go low and cs_n high for a GAP of 2*SCK_DIV cycles.
REQ-024 Each word SHALL take exactly 34*SCK_DIV cycles, GAP included.
REQ-025 busy SHALL rise in the cycle after start is accepted.
REQ-026 done SHALL pulse, and busy fall, in cycle t+NUM_DIGITS*34*SCK_DIV, where t is the acceptance cycle.
REQ-027 start sampled in the done cycle SHALL be ignored; it is accepted from the next cycle on.
REQ-028 Bit and word counters SHALL be sized for the legal parameter range and SHALL NOT wrap mid-word.
REQ-029 done SHALL NOT pulse at the end of INIT.

Reset
REQ-030 While res=1: cs_n=1, sck=0, mosi=0, done=0, busy=1; state and counters cleared to INIT.
REQ-031 res asserted mid-word SHALL abort the word; the bus SHALL be idle on the next edge.
REQ-032 After res falls, INIT SHALL restart from the first init word.
REQ-033 After INIT, busy SHALL equal 0 and the block SHALL idle until start.

Verification
REQ-034 Defaults, release res: SPI monitor captures 0x0C01, 0x093F, 0x0B05, 0x0A08; then busy=0 after 4*68 cycles.
REQ-035 Start with digits=24'h012345 and dp_mask=6'b010100: words 0x0105, 0x0204, 0x0383, 0x0402, 0x0581, 0x0600; done 408 cycles after acceptance.
REQ-036 Change digits and pulse start again mid-frame: captured words unchanged, no second frame, a single done pulse.
REQ-037 res for 1 cycle during bit 7 of word 3: cs_n=1 and sck=0 next cycle; the next word captured is 0x0C01.
REQ-038 NUM_DIGITS=1, SCK_DIV=1: sck period 2 cycles; init words 0x0C01, 0x0901, 0x0B00, 0x0A08; frame done 34 cycles after start.
REQ-039 start held high continuously: back-to-back frames, each accepted in the cycle after done; done pulses every 34*NUM_DIGITS*SCK_DIV+1 cycles.

Source files
------------

// File: rtl/spi_display_driver.sv
// rtl/spi_display_driver.sv - MAX7219-style SPI display driver: init sequence, then one digit frame per start
module spi_display_driver #(
    parameter int NUM_DIGITS = 6,
    parameter int SCK_DIV    = 2,
    parameter int INTENSITY  = 8
) (
    input  logic                    clk,
    input  logic                    res,
    input  logic                    start,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    output logic                    busy,
    output logic                    done,
    output logic                    sck,
    output logic                    mosi,
    output logic                    cs_n
);

    localparam int             CW         = $clog2(2 * SCK_DIV) + 1;
    localparam logic [CW-1:0]  HALF       = CW'(SCK_DIV);
    localparam logic [CW-1:0]  BIT_LAST   = CW'(2 * SCK_DIV - 1);
    localparam logic [CW-1:0]  GAP_LAST   = CW'(2 * SCK_DIV - 2);
    localparam logic [2:0]     LAST_DIGIT = 3'(NUM_DIGITS - 1);
    localparam logic [7:0]     DECODE     = 8'((1 << NUM_DIGITS) - 1);
    localparam logic [7:0]     SCAN_LIMIT = 8'(NUM_DIGITS - 1);
    localparam logic [7:0]     BRIGHTNESS = 8'(INTENSITY);

    typedef enum logic [2:0] {INIT, IDLE, LOAD, SHIFT, GAP} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   div_cnt;
    logic [3:0]      bit_cnt;
    logic [2:0]      word_cnt;
    logic            init_phase;
    logic [15:0]     shreg;
    logic [31:0]     dig_lat;
    logic [7:0]      dp_lat;
    logic            bit_end, gap_end, last_word, accept;

    function automatic logic [15:0] init_word(input logic [1:0] idx);
        case (idx)
            2'd0:    return 16'h0C01;
            2'd1:    return {8'h09, DECODE};
            2'd2:    return {8'h0B, SCAN_LIMIT};
            default: return {8'h0A, BRIGHTNESS};
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (res) state <= INIT;
        else     state <= state_nxt;
    end

    // The LOAD/INIT cycle is part of the inter-word gap, so GAP itself lasts one cycle less.
    always_comb begin
        state_nxt = state;
        bit_end   = 1'b0;
        gap_end   = 1'b0;
        accept    = 1'b0;
        last_word = init_phase ? (word_cnt == 3'd3) : (word_cnt == LAST_DIGIT);
        done      = 1'b0;
        busy      = 1'b1;
        cs_n      = 1'b1;
        sck       = 1'b0;
        mosi      = 1'b0;
        case (state)
            INIT: state_nxt = SHIFT;
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: state_nxt = SHIFT;
            SHIFT: begin
                cs_n = 1'b0;
                sck  = (div_cnt >= HALF);
                mosi = shreg[15];
                if (div_cnt == BIT_LAST) begin
                    bit_end = 1'b1;
                    if (bit_cnt == 4'd15) state_nxt = GAP;
                end
            end
            GAP: begin
                if (div_cnt == GAP_LAST) begin
                    gap_end = 1'b1;
                    if (!last_word) begin
                        state_nxt = init_phase ? INIT : LOAD;
                    end else begin
                        state_nxt = IDLE;
                        if (!init_phase) begin
                            done = 1'b1;
                            busy = 1'b0;
                        end
                    end
                end
            end
            default: state_nxt = INIT;
        endcase
        if (res) begin
            state_nxt = INIT;
            accept    = 1'b0;
            done      = 1'b0;
            busy      = 1'b1;
            cs_n      = 1'b1;
            sck       = 1'b0;
            mosi      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            div_cnt    <= '0;
            bit_cnt    <= '0;
            word_cnt   <= '0;
            init_phase <= 1'b1;
            shreg      <= '0;
            dig_lat    <= '0;
            dp_lat     <= '0;
        end else begin
            case (state)
                INIT: begin
                    shreg   <= init_word(word_cnt[1:0]);
                    div_cnt <= '0;
                    bit_cnt <= '0;
                end
                IDLE: begin
                    if (accept) begin
                        dig_lat  <= 32'(digits);
                        dp_lat   <= 8'(dp_mask);
                        word_cnt <= '0;
                    end
                end
                LOAD: begin
                    shreg   <= {4'h0, {1'b0, word_cnt} + 4'd1, dp_lat[word_cnt], 3'b000,
                                dig_lat[{word_cnt, 2'b00} +: 4]};
                    div_cnt <= '0;
                    bit_cnt <= '0;
                end
                SHIFT: begin
                    if (bit_end) begin
                        div_cnt <= '0;
                        if (bit_cnt != 4'd15) begin
                            bit_cnt <= bit_cnt + 4'd1;
                            shreg   <= {shreg[14:0], 1'b0};
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_end) begin
                        div_cnt <= '0;
                        if (last_word) init_phase <= 1'b0;
                        else           word_cnt   <= word_cnt + 3'd1;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_display_driver.sv
// tb/tb_spi_display_driver.sv - bench for spi_display_driver (default and 1-digit/divide-by-1 builds)
module tb_spi_display_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        res_a = 1'b1, start_a = 1'b0;
    logic [23:0] digits_a = '0;
    logic [5:0]  dp_a = '0;
    logic        busy_a, done_a, sck_a, mosi_a, cs_n_a;

    logic        res_b = 1'b1, start_b = 1'b0;
    logic [3:0]  digits_b = '0;
    logic [0:0]  dp_b = '0;
    logic        busy_b, done_b, sck_b, mosi_b, cs_n_b;

    spi_display_driver #(.NUM_DIGITS(6), .SCK_DIV(2), .INTENSITY(8)) dut_a (
        .clk(clk), .res(res_a), .start(start_a), .digits(digits_a), .dp_mask(dp_a),
        .busy(busy_a), .done(done_a), .sck(sck_a), .mosi(mosi_a), .cs_n(cs_n_a)
    );

    spi_display_driver #(.NUM_DIGITS(1), .SCK_DIV(1), .INTENSITY(8)) dut_b (
        .clk(clk), .res(res_b), .start(start_b), .digits(digits_b), .dp_mask(dp_b),
        .busy(busy_b), .done(done_b), .sck(sck_b), .mosi(mosi_b), .cs_n(cs_n_b)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // SPI mode-0 monitor: capture on rising sck, a word counts only if 16 bits arrive before cs_n rises
    logic [15:0] q_a[$];
    logic [15:0] q_b[$];
    logic [1:0]  prev_sck = 2'b00, prev_mosi = 2'b00, prev_cs = 2'b11;
    logic [15:0] sh[2];
    int          nbits[2];

    always @(negedge clk) begin
        logic [1:0] c_sck, c_mosi, c_cs;
        c_sck  = {sck_b, sck_a};
        c_mosi = {mosi_b, mosi_a};
        c_cs   = {cs_n_b, cs_n_a};
        for (int k = 0; k < 2; k++) begin
            if (c_mosi[k] !== prev_mosi[k]) begin
                total++;
                assert (c_sck[k] === 1'b0) else begin
                    bad++;
                    $error("FAIL mode0_inst%0d observed sck=%b expected 0", k, c_sck[k]);
                end
            end
            if (!c_cs[k] && c_sck[k] && !prev_sck[k]) begin
                sh[k] = {sh[k][14:0], c_mosi[k]};
                nbits[k]++;
            end
            if (c_cs[k] && !prev_cs[k]) begin
                if (nbits[k] == 16) begin
                    if (k == 0) q_a.push_back(sh[k]);
                    else        q_b.push_back(sh[k]);
                end
                nbits[k] = 0;
            end
        end
        prev_sck  = c_sck;
        prev_mosi = c_mosi;
        prev_cs   = c_cs;
    end

    function automatic logic [15:0] dword(input int i, input logic [31:0] d, input logic [7:0] p);
        return 16'(((i + 1) * 256) + (int'(p[i]) * 128) + ((d >> (4 * i)) & 15));
    endfunction

    task automatic check_frame_a(input string tag, input logic [23:0] d, input logic [5:0] p, input int base);
        for (int i = 0; i < 6; i++)
            chk($sformatf("%s_w%0d", tag, i), {16'h0, q_a[base + i]}, {16'h0, dword(i, {8'h0, d}, {2'b0, p})});
    endtask

    task automatic check_init_a(input string tag);
        logic [15:0] exp[4] = '{16'h0C01, 16'h093F, 16'h0B05, 16'h0A08};
        chk({tag, "_count"}, q_a.size(), 4);
        if (q_a.size() >= 4)
            for (int i = 0; i < 4; i++) chk($sformatf("%s_w%0d", tag, i), {16'h0, q_a[i]}, {16'h0, exp[i]});
    endtask

    // Frame on instance A, called in an idle cycle; acceptance cycle is n=0
    task automatic frame_a(input string tag, input logic [23:0] d, input logic [5:0] p, input bit disturb);
        int n, pulses;
        q_a.delete();
        digits_a = d; dp_a = p; start_a = 1'b1;
        n = 0; pulses = 0;
        @(negedge clk); n = 1;
        start_a = 1'b0;
        chk({tag, "_busy_rise"}, busy_a, 1);
        digits_a = 24'($urandom); dp_a = 6'($urandom);
        while (done_a !== 1'b1 && n < 2000) begin
            if (disturb && n == 50) begin
                start_a = 1'b1; digits_a = 24'($urandom); dp_a = 6'($urandom);
            end
            if (n == 52) start_a = 1'b0;
            @(negedge clk); n++;
        end
        chk({tag, "_latency"}, n, 408);
        chk({tag, "_busy_at_done"}, busy_a, 0);
        for (int i = 0; i < 450; i++) begin
            @(negedge clk);
            if (done_a === 1'b1) pulses++;
        end
        chk({tag, "_extra_done"}, pulses, 0);
        chk({tag, "_words"}, q_a.size(), 6);
        if (q_a.size() == 6) check_frame_a(tag, d, p, 0);
    endtask

    initial begin
        int n;
        logic [23:0] d;
        logic [5:0]  p;

        repeat (3) @(negedge clk);
        chk("rst_cs_n", cs_n_a, 1);
        chk("rst_sck", sck_a, 0);
        chk("rst_mosi", mosi_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_busy", busy_a, 1);

        res_a = 1'b0; n = 0;
        while (busy_a !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
        chk("init_latency", n, 272);
        check_init_a("init");
        repeat (5) @(negedge clk);
        chk("idle_busy", busy_a, 0);

        frame_a("f_dir", 24'h012345, 6'b010100, 1'b0);
        frame_a("f_dist", 24'($urandom), 6'($urandom), 1'b1);
        for (int r = 0; r < 3; r++) begin
            d = 24'($urandom);
            d[3:0] = 4'(10 + r);
            d[23:20] = 4'hF;
            frame_a($sformatf("f_rnd%0d", r), d, 6'($urandom), 1'b0);
        end

        // start held high: back-to-back frames
        q_a.delete();
        d = 24'hFA9876; p = 6'b100001;
        digits_a = d; dp_a = p; start_a = 1'b1;
        n = 0;
        while (done_a !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        chk("held_first", n, 408);
        for (int f = 0; f < 2; f++) begin
            n = 0;
            @(negedge clk); n++;
            while (done_a !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
            chk($sformatf("held_period%0d", f), n, 409);
        end
        start_a = 1'b0;
        n = 0;
        for (int i = 0; i < 450; i++) begin @(negedge clk); if (done_a === 1'b1) n++; end
        chk("held_stop", n, 0);
        chk("held_words", q_a.size(), 18);
        if (q_a.size() == 18) for (int f = 0; f < 3; f++) check_frame_a($sformatf("held%0d", f), d, p, 6 * f);

        // reset during bit 7 of word 3
        q_a.delete();
        d = 24'($urandom); p = 6'($urandom);
        digits_a = d; dp_a = p; start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        repeat (238) @(negedge clk);
        res_a = 1'b1;
        @(negedge clk);
        res_a = 1'b0;
        chk("abort_cs_n", cs_n_a, 1);
        chk("abort_sck", sck_a, 0);
        chk("abort_busy", busy_a, 1);
        chk("abort_words", q_a.size(), 3);
        if (q_a.size() == 3) check_frame_a_part(d, p);
        q_a.delete();
        n = 0;
        while (busy_a !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
        chk("reinit_latency", n, 272);
        check_init_a("reinit");

        // 1 digit, divide-by-1 build
        res_b = 1'b0; n = 0;
        while (busy_b !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
        chk("b_init_latency", n, 136);
        chk("b_init_count", q_b.size(), 4);
        if (q_b.size() == 4) begin
            chk("b_init_w0", q_b[0], 16'h0C01);
            chk("b_init_w1", q_b[1], 16'h0901);
            chk("b_init_w2", q_b[2], 16'h0B00);
            chk("b_init_w3", q_b[3], 16'h0A08);
        end
        for (int r = 0; r < 2; r++) begin
            q_b.delete();
            digits_b = 4'($urandom); dp_b = 1'($urandom);
            d = {20'h0, digits_b}; p = {5'h0, dp_b};
            start_b = 1'b1; n = 0;
            @(negedge clk); n++;
            start_b = 1'b0;
            while (done_b !== 1'b1 && n < 500) begin @(negedge clk); n++; end
            chk($sformatf("b_frame%0d_latency", r), n, 34);
            repeat (5) @(negedge clk);
            chk($sformatf("b_frame%0d_count", r), q_b.size(), 1);
            if (q_b.size() == 1) chk($sformatf("b_frame%0d_word", r), {16'h0, q_b[0]}, {16'h0, dword(0, {8'h0, d}, {2'b0, p})});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    task automatic check_frame_a_part(input logic [23:0] d, input logic [5:0] p);
        for (int i = 0; i < 3; i++)
            chk($sformatf("abort_w%0d", i), {16'h0, q_a[i]}, {16'h0, dword(i, {8'h0, d}, {2'b0, p})});
    endtask

endmodule
